ucsbece154b_gshare_predictor: RTL

Gshare branch predictor that supplies the fetch stage with a predicted direction and target each cycle and is trained by the execute stage. It feeds the pipelined datapath's fetch-PC mux and consumes resolved branch and jump outcomes plus misprediction flags from execute. It holds a direct-mapped BTB, a PHT of 2-bit counters indexed by GHR XOR PC, and a speculatively updated GHR that is repaired on misprediction.

---
 rtl/ucsbece154b_gshare_predictor_pkg.sv | 24 ++
 rtl/ucsbece154b_btb.sv | 51 +++++
 rtl/ucsbece154b_gshare_predictor.sv | 112 +++++++++++
 3 files changed

// File: rtl/ucsbece154b_gshare_predictor_pkg.sv
// Shared definitions for the gshare predictor: opcodes, counter encodings,
// default sizes and the saturating counter update.
package ucsbece154b_gshare_predictor_pkg;

  localparam int DEF_NUM_BTB_ENTRIES = 32;
  localparam int DEF_NUM_GHR_BITS    = 5;

  localparam logic [6:0] op_branch = 7'b1100011;
  localparam logic [6:0] op_jal    = 7'b1101111;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  // Saturating 2-bit counter step; holds at the strong states.
  function automatic logic [1:0] ctrNext(input logic [1:0] c, input logic taken);
    if (taken) return (c == CTR_ST)  ? c : c + 2'd1;
    else       return (c == CTR_SNT) ? c : c - 2'd1;
  endfunction

endpackage

// File: rtl/ucsbece154b_btb.sv
// Direct-mapped branch target buffer. Addresses are word addresses (PC[31:2]).
// Read is combinational from current contents; a write lands on the clock edge
// and overwrites whatever occupied the index.
module ucsbece154b_btb
  import ucsbece154b_gshare_predictor_pkg::*;
#(
  parameter int NUM_BTB_ENTRIES = DEF_NUM_BTB_ENTRIES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] rdAddr,
  output logic        rdHit,
  output logic [31:0] rdTarget,
  output logic        rdIsJump,
  input  logic        wrEn,
  input  logic [29:0] wrAddr,
  input  logic [31:0] wrTarget,
  input  logic        wrIsJump
);

  localparam int IW = $clog2(NUM_BTB_ENTRIES);
  localparam int TW = 30 - IW;

  logic [NUM_BTB_ENTRIES-1:0]         valid;
  logic [NUM_BTB_ENTRIES-1:0]         isJump;
  logic [NUM_BTB_ENTRIES-1:0][TW-1:0] tags;
  logic [NUM_BTB_ENTRIES-1:0][31:0]   targets;
  logic [IW-1:0]                      rIdx, wIdx;

  assign rIdx     = rdAddr[IW-1:0];
  assign wIdx     = wrAddr[IW-1:0];
  assign rdHit    = valid[rIdx] && (tags[rIdx] == rdAddr[29:IW]);
  assign rdTarget = rdHit ? targets[rIdx] : 32'd0;
  assign rdIsJump = rdHit && isJump[rIdx];

  // Valid bits: the only state that needs clearing on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     valid       <= '0;
    else if (wrEn) valid[wIdx] <= 1'b1;
  end

  // Payload arrays: meaningless until their valid bit is set.
  always_ff @(posedge clk) begin
    if (wrEn) begin
      tags[wIdx]    <= wrAddr[29:IW];
      targets[wIdx] <= wrTarget;
      isJump[wIdx]  <= wrIsJump;
    end
  end

endmodule

// File: rtl/ucsbece154b_gshare_predictor.sv
// Gshare predictor: BTB + PHT indexed by GHR^PC, speculative GHR with
// checkpoints carried F->D->E so execute can train and repair the history.
module ucsbece154b_gshare_predictor
  import ucsbece154b_gshare_predictor_pkg::*;
#(
  parameter int NUM_BTB_ENTRIES = DEF_NUM_BTB_ENTRIES,
  parameter int NUM_GHR_BITS    = DEF_NUM_GHR_BITS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pcf_i,
  input  logic [6:0]  opf_i,
  input  logic        stallf_i,
  input  logic        stalld_i,
  input  logic        flushd_i,
  input  logic        flushe_i,
  input  logic        branche_i,
  input  logic        jumpe_i,
  input  logic        takene_i,
  input  logic [31:0] pce_i,
  input  logic [31:0] targete_i,
  input  logic        mispredicte_i,
  output logic        takenf_o,
  output logic [31:0] targetf_o
);

  localparam int G     = NUM_GHR_BITS;
  localparam int PHT_N = 1 << G;

  typedef struct packed {
    logic         vld;
    logic         isBranch;
    logic [G-1:0] phtIdx;
    logic [G-1:0] ghr;
  } ckpt_t;

  logic [G-1:0]            ghr, ghrNext, phtIdxF;
  logic [PHT_N-1:0][1:0]   pht;
  ckpt_t                   ckptF, ckptD, ckptE;
  logic                    isBranchF, isJalF;
  logic                    btbHit, btbIsJump, btbWrEn;
  logic [31:0]             btbTarget;
  logic                    unusedBits;

  assign isBranchF = (opf_i == op_branch);
  assign isJalF    = (opf_i == op_jal);
  assign phtIdxF   = ghr ^ pcf_i[G+1:2];

  ucsbece154b_btb #(.NUM_BTB_ENTRIES(NUM_BTB_ENTRIES)) btb (
    .clk      (clk),
    .reset    (reset),
    .rdAddr   (pcf_i[31:2]),
    .rdHit    (btbHit),
    .rdTarget (btbTarget),
    .rdIsJump (btbIsJump),
    .wrEn     (btbWrEn),
    .wrAddr   (pce_i[31:2]),
    .wrTarget (targete_i),
    .wrIsJump (jumpe_i)
  );

  assign takenf_o  = btbHit && ((isJalF && btbIsJump) || (isBranchF && pht[phtIdxF][1]));
  assign targetf_o = btbTarget;

  // Only resolved-taken branches/jumps from a live E slot allocate.
  assign btbWrEn = ckptE.vld && (branche_i || jumpe_i) && takene_i;

  // A stalled fetch feeds a bubble into decode.
  assign ckptF = '{vld: !stallf_i, isBranch: isBranchF, phtIdx: phtIdxF, ghr: ghr};

  // Byte-offset PC bits and the E-slot branch flag are not needed for lookup.
  assign unusedBits = ^{pcf_i[1:0], pce_i[1:0], ckptE.isBranch};

  // Checkpoint pipeline: D holds on decode stall, flushes clear their slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ckptD <= '0;
      ckptE <= '0;
    end else begin
      if (flushd_i)       ckptD <= '0;
      else if (!stalld_i) ckptD <= ckptF;
      if (flushe_i)       ckptE <= '0;
      else                ckptE <= ckptD;
    end
  end

  // Next history: repair from the E checkpoint wins over speculative shift.
  always_comb begin
    ghrNext = ghr;
    if (mispredicte_i && branche_i)
      ghrNext = {ckptE.ghr[G-2:0], takene_i};
    else if (mispredicte_i && jumpe_i)
      ghrNext = ckptE.ghr;
    else if (isBranchF && !stallf_i && !flushd_i && !mispredicte_i)
      ghrNext = {ghr[G-2:0], takenf_o};
  end

  // Global history register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ghr <= '0;
    else       ghr <= ghrNext;
  end

  // PHT training with the index captured at fetch time.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      pht <= {PHT_N{CTR_WNT}};
    else if (ckptE.vld && branche_i)
      pht[ckptE.phtIdx] <= ctrNext(pht[ckptE.phtIdx], takene_i);
  end

endmodule
